// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: fetches into an internal IR, decodes, and sequences
// the datapath through DECODE/EXEC/MEM/WB with a memory wait-state watchdog.

package cpu_types_pkg;
  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;
endpackage

module multicycle_control_unit
  import cpu_types_pkg::*;
#(
  parameter int          REG_AW      = 5,
  parameter int          MEM_TIMEOUT = 16,
  parameter logic [5:0]  HALT_OP     = 6'h3F
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [31:0]       imemLoad,
  input  logic              zero,
  output logic              iREN,
  output logic              dREN,
  output logic              dWEN,
  output logic              irWEN,
  output logic              pcWEN,
  output logic              RegWrite,
  output logic [1:0]        JmpSel,
  output logic [1:0]        MemtoReg,
  output logic [1:0]        aluSrc,
  output logic [1:0]        RegDst,
  output aluop_t            aluOp,
  output logic [4:0]        shamt,
  output logic [REG_AW-1:0] regS,
  output logic [REG_AW-1:0] regT,
  output logic [REG_AW-1:0] regD,
  output logic              halt,
  output logic              mem_err
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ILLEGAL, C_RTYPE, C_JR, C_BEQ, C_BNE, C_J, C_JAL,
    C_LW, C_SW, C_IMM, C_LUI, C_HALT
  } iclass_t;

  state_t           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_q, halt_d;
  logic             mem_err_q, mem_err_d;

  iclass_t          cls;
  aluop_t           dec_aluop;
  logic [1:0]       dec_alusrc;
  logic             wd_fire;

  assign shamt   = ir_q[10:6];
  assign halt    = halt_q;
  assign mem_err = mem_err_q;

  // Register indices are zero-extended or truncated from the 5-bit IR fields.
  generate
    for (genvar gi = 0; gi < REG_AW; gi++) begin : g_regidx
      if (gi < 5) begin : g_bit
        assign regS[gi] = ir_q[21+gi];
        assign regT[gi] = ir_q[16+gi];
        assign regD[gi] = ir_q[11+gi];
      end else begin : g_pad
        assign regS[gi] = 1'b0;
        assign regT[gi] = 1'b0;
        assign regD[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    cls        = C_ILLEGAL;
    dec_aluop  = ALU_ADD;
    dec_alusrc = 2'd0;
    if (ir_q[31:26] == HALT_OP) begin
      cls = C_HALT;
    end else begin
      case (ir_q[31:26])
        6'h00: begin
          cls = C_RTYPE;
          case (ir_q[5:0])
            6'h21:   dec_aluop = ALU_ADD;
            6'h23:   dec_aluop = ALU_SUB;
            6'h24:   dec_aluop = ALU_AND;
            6'h25:   dec_aluop = ALU_OR;
            6'h26:   dec_aluop = ALU_XOR;
            6'h27:   dec_aluop = ALU_NOR;
            6'h2A:   dec_aluop = ALU_SLT;
            6'h2B:   dec_aluop = ALU_SLTU;
            6'h00:   dec_aluop = ALU_SLL;
            6'h02:   dec_aluop = ALU_SRL;
            6'h08:   cls = C_JR;
            default: cls = C_ILLEGAL;
          endcase
        end
        6'h02: cls = C_J;
        6'h03: cls = C_JAL;
        6'h04: begin cls = C_BEQ; dec_aluop = ALU_SUB; end
        6'h05: begin cls = C_BNE; dec_aluop = ALU_SUB; end
        6'h09: begin cls = C_IMM; dec_alusrc = 2'd1; end
        6'h0C: begin cls = C_IMM; dec_aluop = ALU_AND; dec_alusrc = 2'd2; end
        6'h0D: begin cls = C_IMM; dec_aluop = ALU_OR;  dec_alusrc = 2'd2; end
        6'h0F: cls = C_LUI;
        6'h23: begin cls = C_LW; dec_alusrc = 2'd1; end
        6'h2B: begin cls = C_SW; dec_alusrc = 2'd1; end
        default: cls = C_ILLEGAL;
      endcase
    end
  end

  // Fires on the last permitted wait cycle; a hit in that same cycle takes priority.
  assign wd_fire = (MEM_TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    cnt_d     = '0;
    halt_d    = halt_q;
    mem_err_d = mem_err_q;
    iREN      = 1'b0;
    dREN      = 1'b0;
    dWEN      = 1'b0;
    irWEN     = 1'b0;
    pcWEN     = 1'b0;
    RegWrite  = 1'b0;
    JmpSel    = 2'd0;
    MemtoReg  = 2'd0;
    aluSrc    = 2'd0;
    RegDst    = 2'd0;
    aluOp     = ALU_SLL;

    case (state_q)
      S_FETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          irWEN   = 1'b1;
          ir_d    = imemLoad;
          state_d = S_DECODE;
        end else if (wd_fire) begin
          halt_d    = 1'b1;
          mem_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (cls == C_HALT) begin
          halt_d  = 1'b1;
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        aluOp  = dec_aluop;
        aluSrc = dec_alusrc;
        case (cls)
          C_BEQ:   begin pcWEN = 1'b1; JmpSel = zero ? 2'd1 : 2'd0; state_d = S_FETCH; end
          C_BNE:   begin pcWEN = 1'b1; JmpSel = zero ? 2'd0 : 2'd1; state_d = S_FETCH; end
          C_J:     begin pcWEN = 1'b1; JmpSel = 2'd2; state_d = S_FETCH; end
          C_JR:    begin pcWEN = 1'b1; JmpSel = 2'd3; state_d = S_FETCH; end
          C_LW, C_SW: state_d = S_MEM;
          C_JAL, C_RTYPE, C_IMM, C_LUI: state_d = S_WB;
          default: begin pcWEN = 1'b1; state_d = S_FETCH; end
        endcase
      end
      S_MEM: begin
        aluOp  = dec_aluop;
        aluSrc = dec_alusrc;
        dREN   = (cls == C_LW);
        dWEN   = (cls == C_SW);
        if (dhit) begin
          if (cls == C_LW) begin
            state_d = S_WB;
          end else begin
            pcWEN   = 1'b1;
            state_d = S_FETCH;
          end
        end else if (wd_fire) begin
          halt_d    = 1'b1;
          mem_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        aluOp    = dec_aluop;
        aluSrc   = dec_alusrc;
        RegWrite = 1'b1;
        pcWEN    = 1'b1;
        state_d  = S_FETCH;
        case (cls)
          C_JAL:   begin RegDst = 2'd2; MemtoReg = 2'd2; JmpSel = 2'd2; end
          C_LW:    MemtoReg = 2'd1;
          C_LUI:   MemtoReg = 2'd3;
          C_RTYPE: RegDst = 2'd1;
          default: RegDst = 2'd0;
        endcase
      end
      default: begin
        halt_d  = 1'b1;
        state_d = S_HALT;
      end
    endcase

    // Strobes and selects stay quiet for the whole time reset is asserted.
    if (!nRST) begin
      iREN     = 1'b0;
      dREN     = 1'b0;
      dWEN     = 1'b0;
      irWEN    = 1'b0;
      pcWEN    = 1'b0;
      RegWrite = 1'b0;
      JmpSel   = 2'd0;
      MemtoReg = 2'd0;
      aluSrc   = 2'd0;
      RegDst   = 2'd0;
      aluOp    = ALU_SLL;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      cnt_q     <= '0;
      halt_q    <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      halt_q    <= halt_d;
      mem_err_q <= mem_err_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit with a 4-cycle memory watchdog.
module tb_multicycle_control_unit;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST, ihit, dhit, zero;
  logic [31:0] imemLoad;
  logic        iREN, dREN, dWEN, irWEN, pcWEN, RegWrite, halt, mem_err;
  logic [1:0]  JmpSel, MemtoReg, aluSrc, RegDst;
  aluop_t      aluOp;
  logic [4:0]  shamt, regS, regT, regD;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  multicycle_control_unit #(.REG_AW(5), .MEM_TIMEOUT(4), .HALT_OP(6'h3F)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .imemLoad(imemLoad), .zero(zero),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .irWEN(irWEN), .pcWEN(pcWEN),
    .RegWrite(RegWrite), .JmpSel(JmpSel), .MemtoReg(MemtoReg), .aluSrc(aluSrc),
    .RegDst(RegDst), .aluOp(aluOp), .shamt(shamt), .regS(regS), .regT(regT),
    .regD(regD), .halt(halt), .mem_err(mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Enter in a FETCH cycle; leave settled in the EXEC cycle of word w.
  task automatic to_exec(input logic [31:0] w);
    ihit = 1'b1; imemLoad = w; #1;
    chk("fetch_irWEN", irWEN, 1);
    cyc(); ihit = 1'b0; #1;
    chk("decode_iREN", iREN, 0);
    cyc(); #1;
  endtask

  task automatic branch(input string tag, input logic [31:0] w, input logic z, input logic [1:0] js);
    to_exec(w);
    zero = z; #1;
    $display("branch %s ir=%h zero=%0b pcWEN=%0b JmpSel=%0d", tag, w, z, pcWEN, JmpSel);
    chk({tag, "_pcWEN"}, pcWEN, 1);
    chk({tag, "_JmpSel"}, JmpSel, js);
    chk({tag, "_RegWrite"}, RegWrite, 0);
    cyc(); zero = 1'b0; #1;
    chk({tag, "_refetch"}, iREN, 1);
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; zero = 1'b0; imemLoad = 32'h0;
    cyc(); cyc(); #1;
    chk("rst_iREN", iREN, 0);
    chk("rst_halt", halt, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_regS", regS, 0);
    chk("rst_aluOp", aluOp, ALU_SLL);
    nRST = 1'b1; #1;
    chk("fetch_iREN", iREN, 1);
    chk("fetch_noirWEN", irWEN, 0);

    // ADDU $3,$1,$2
    to_exec(32'h00221821);
    $display("addu exec aluOp=%0d RegWrite=%0b", aluOp, RegWrite);
    chk("addu_exec_aluOp", aluOp, ALU_ADD);
    chk("addu_exec_RegWrite", RegWrite, 0);
    cyc(); #1;
    $display("addu wb RegWrite=%0b RegDst=%0d regD=%0d", RegWrite, RegDst, regD);
    chk("addu_wb_RegWrite", RegWrite, 1);
    chk("addu_wb_RegDst", RegDst, 1);
    chk("addu_wb_aluOp", aluOp, ALU_ADD);
    chk("addu_wb_regD", regD, 3);
    chk("addu_wb_regS", regS, 1);
    chk("addu_wb_regT", regT, 2);
    cyc(); #1;
    chk("addu_next_iREN", iREN, 1);
    chk("addu_next_RegWrite", RegWrite, 0);

    // LW $5,4($1), dhit on the 4th MEM cycle
    to_exec(32'h8C250004);
    chk("lw_exec_aluSrc", aluSrc, 1);
    chk("lw_exec_dREN", dREN, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lw_mem_dREN", dREN, 1);
      chk("lw_mem_dWEN", dWEN, 0);
      cyc();
    end
    dhit = 1'b1; #1;
    chk("lw_mem4_dREN", dREN, 1);
    cyc(); dhit = 1'b0; #1;
    $display("lw wb MemtoReg=%0d RegDst=%0d RegWrite=%0b mem_err=%0b", MemtoReg, RegDst, RegWrite, mem_err);
    chk("lw_wb_dREN", dREN, 0);
    chk("lw_wb_MemtoReg", MemtoReg, 1);
    chk("lw_wb_RegDst", RegDst, 0);
    chk("lw_wb_RegWrite", RegWrite, 1);
    chk("lw_wb_mem_err", mem_err, 0);
    cyc(); #1;

    branch("beq_z1", 32'h10220003, 1'b1, 2'd1);
    branch("beq_z0", 32'h10220003, 1'b0, 2'd0);
    branch("bne_z1", 32'h14220003, 1'b1, 2'd0);
    branch("bne_z0", 32'h14220003, 1'b0, 2'd1);
    branch("jr", 32'h03E00008, 1'b0, 2'd3);
    branch("illegal", 32'h20000000, 1'b0, 2'd0);

    // ORI $2,$1,5
    to_exec(32'h34220005);
    chk("ori_aluSrc", aluSrc, 2);
    chk("ori_aluOp", aluOp, ALU_OR);
    cyc(); #1;
    chk("ori_wb_RegDst", RegDst, 0);
    cyc(); #1;

    // LUI $1,0x1234
    to_exec(32'h3C011234);
    cyc(); #1;
    chk("lui_wb_MemtoReg", MemtoReg, 3);
    chk("lui_wb_RegWrite", RegWrite, 1);
    cyc(); #1;

    // JAL
    to_exec(32'h0C000010);
    chk("jal_exec_pcWEN", pcWEN, 0);
    cyc(); #1;
    $display("jal wb RegDst=%0d MemtoReg=%0d JmpSel=%0d RegWrite=%0b", RegDst, MemtoReg, JmpSel, RegWrite);
    chk("jal_wb_RegDst", RegDst, 2);
    chk("jal_wb_MemtoReg", MemtoReg, 2);
    chk("jal_wb_JmpSel", JmpSel, 2);
    chk("jal_wb_RegWrite", RegWrite, 1);
    cyc(); #1;

    // Watchdog: 4 FETCH cycles with no ihit
    for (int i = 0; i < 4; i++) begin
      chk("wd_fetch_iREN", iREN, 1);
      chk("wd_fetch_halt", halt, 0);
      cyc(); #1;
    end
    $display("watchdog mem_err=%0b halt=%0b iREN=%0b", mem_err, halt, iREN);
    chk("wd_mem_err", mem_err, 1);
    chk("wd_halt", halt, 1);
    chk("wd_iREN", iREN, 0);
    nRST = 1'b0; cyc(); nRST = 1'b1; #1;
    chk("wd_rst_mem_err", mem_err, 0);
    chk("wd_rst_halt", halt, 0);

    // ihit on the 4th FETCH cycle wins over the watchdog
    for (int i = 0; i < 3; i++) cyc();
    to_exec(32'h8C250004);
    $display("late ihit mem_err=%0b halt=%0b", mem_err, halt);
    chk("late_mem_err", mem_err, 0);
    chk("late_halt", halt, 0);
    cyc(); #1;
    chk("abort_mem_dREN", dREN, 1);
    nRST = 1'b0; #1;
    chk("abort_rst_dREN", dREN, 0);
    cyc(); nRST = 1'b1; #1;
    chk("abort_fetch_iREN", iREN, 1);
    chk("abort_fetch_dREN", dREN, 0);
    chk("abort_RegWrite", RegWrite, 0);

    // SW $5,8($1) with immediate dhit
    to_exec(32'hAC250008);
    cyc(); dhit = 1'b1; #1;
    chk("sw_dWEN", dWEN, 1);
    chk("sw_dREN", dREN, 0);
    chk("sw_pcWEN", pcWEN, 1);
    chk("sw_RegWrite", RegWrite, 0);
    cyc(); dhit = 1'b0; #1;
    chk("sw_refetch", iREN, 1);

    // HALT opcode
    ihit = 1'b1; imemLoad = 32'hFC000000; #1;
    cyc(); ihit = 1'b0; #1;
    chk("halt_decode", halt, 0);
    cyc(); #1;
    $display("halt op halt=%0b iREN=%0b", halt, iREN);
    chk("halt_set", halt, 1);
    chk("halt_iREN", iREN, 0);
    for (int i = 0; i < 4; i++) begin
      ihit = ~ihit; dhit = ~dhit; #1;
      chk("halt_sticky", halt, 1);
      chk("halt_no_irWEN", irWEN, 0);
      cyc();
    end
    ihit = 1'b0; dhit = 1'b0;
    nRST = 1'b0; cyc(); #1;
    chk("halt_rst", halt, 0);
    nRST = 1'b1; #1;
    chk("halt_rst_iREN", iREN, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench time limit");
  end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised multicycle successor to the single-cycle decoder: a sequential FSM that fetches a MIPS instruction into an internal instruction register and decodes it. It then sequences the datapath through DECODE/EXEC/MEM/WB, emitting per-state strobes and waiting on ihit/dhit handshakes. It sits between the memory request interface and the datapath register file, ALU and PC. A wait-state watchdog converts a stalled memory into a sticky error halt.

Parameters:
REG_AW, 5, register-index width of regS/regT/regD (IR fields zero-extended or truncated to REG_AW)
MEM_TIMEOUT, 16, max wait cycles for ihit/dhit before error; 0 disables the watchdog
HALT_OP, 6'h3F, opcode that halts the core

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  synchronous active-low reset
ihit  in  1  instruction memory ready
dhit  in  1  data memory ready
imemLoad  in  32  instruction word from imem
zero  in  1  ALU zero flag
iREN  out  1  instruction read request
dREN  out  1  data read request
dWEN  out  1  data write request
irWEN  out  1  IR load strobe (mirrors internal IR capture)
pcWEN  out  1  PC update strobe
RegWrite  out  1  register-file write enable
JmpSel  out  2  PC source: 0 PC+4, 1 branch target, 2 jump target, 3 rs (JR)
MemtoReg  out  2  WB source: 0 ALU, 1 dmem, 2 PC+4 (JAL), 3 LUI immediate
aluSrc  out  2  ALU B: 0 rt, 1 sign-ext imm, 2 zero-ext imm
RegDst  out  2  dest: 0 rt, 1 rd, 2 r31
aluOp  out  aluop_t  ALU operation (cpu_types_pkg)
shamt  out  5  IR[10:6]
regS, regT, regD  out  REG_AW  IR[25:21], IR[20:16], IR[15:11]
halt  out  1  core halted (sticky)
mem_err  out  1  watchdog fired (sticky)

Behaviour:
- One clock. Reset is synchronous, active-low, on port nRST; clock is CLK. While nRST=0 at a CLK edge: state=FETCH, IR=0, wait counter=0, halt=0, mem_err=0. All strobes (iREN, dREN, dWEN, irWEN, pcWEN, RegWrite) are 0 during reset and in every state except where listed. Mux selects and aluOp reset to 0. Reset mid-instruction aborts it with no write.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: iREN=1. On ihit: irWEN=1, IR<=imemLoad, -> DECODE. No ihit: stay, counter++.
- DECODE: one cycle. Fields from IR. Opcode HALT_OP -> HALT. Otherwise -> EXEC.
- EXEC: one cycle; aluOp/aluSrc driven by the decoded op.
  - BEQ: pcWEN=1, JmpSel=1 if zero, else 0. BNE: JmpSel=1 if !zero, else 0. Both -> FETCH.
  - J: pcWEN=1, JmpSel=2, -> FETCH. JR: pcWEN=1, JmpSel=3, -> FETCH.
  - JAL: -> WB.
  - LW/SW: aluOp=ALU_ADD, aluSrc=1, -> MEM.
  - R-type/ADDIU/ORI/ANDI/LUI: -> WB.
  - Illegal opcode/funct: pcWEN=1, JmpSel=0, -> FETCH, no register write.
- MEM: LW drives dREN=1, SW drives dWEN=1, held until dhit; counter++ each non-hit cycle. On dhit: LW -> WB; SW -> FETCH with pcWEN=1, JmpSel=0.
- WB: RegWrite=1 and pcWEN=1, -> FETCH.
  - JAL: RegDst=2, MemtoReg=2, JmpSel=2.
  - LW: MemtoReg=1.
  - LUI: MemtoReg=3.
  - Otherwise MemtoReg=0 and JmpSel=0; RegDst=1 for R-type, 0 for immediates.
- Decode map:
  - R-type funct: 21 ADDU->ALU_ADD, 23 SUBU->ALU_SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU, 00 SLL, 02 SRL, 08 JR.
  - Opcodes: ADDIU 09 (aluSrc=1), ANDI 0C / ORI 0D (aluSrc=2), LUI 0F.
- Watchdog: the counter is cleared on every state entry. If the counter reaches MEM_TIMEOUT in FETCH or MEM: mem_err=1, halt=1, -> HALT, all requests dropped the same edge. A hit arriving on the timeout cycle wins; the instruction proceeds.
- HALT: all strobes 0, halt=1; exited only by reset. ihit/dhit are ignored.
- dREN and dWEN are never both 1. At most one of pcWEN/RegWrite edges per instruction beyond WB.

Test Plan:
- ADDU $3,$1,$2 (IR=0x00221821), ihit immediate -> FETCH, DECODE, EXEC, WB = 4 cycles; WB has RegWrite=1, RegDst=1, aluOp=ALU_ADD, regD=3.
- LW $5,4($1) with dhit delayed 3 cycles -> dREN=1 for exactly 4 MEM cycles; then WB with MemtoReg=1, RegDst=0, RegWrite=1.
- BEQ with zero=1 -> EXEC pcWEN=1, JmpSel=1, no RegWrite. With zero=0 -> JmpSel=0. BNE gives the inverted results.
- JAL 0x0C000010 -> WB: RegDst=2, MemtoReg=2, JmpSel=2, RegWrite=1.
- IR=0xFC000000 -> halt=1 two cycles after ihit. halt stays 1 with ihit toggling, and clears only on nRST=0 at an edge.
- MEM_TIMEOUT=4, ihit held 0 -> mem_err=1 and halt=1 after 4 FETCH cycles. Repeat with ihit on cycle 4 -> no error. nRST=0 during MEM -> dREN=0 next cycle, state FETCH.
